// File: rtl/fg_prog_pkg.sv
// Shared types and constants for the floating-gate tile programming sequencer.
// Holds FSM states, operation mode encodings and default sizing.
package fg_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        MEAS,
        DONE
    } state_t;

    localparam logic [1:0] MODE_MEAS = 2'b00;
    localparam logic [1:0] MODE_INJ  = 2'b01;

    localparam int DEF_ROWS    = 10;
    localparam int DEF_COLS    = 22;
    localparam int DEF_ISLANDS = 2;
    localparam int DEF_SETTLE  = 4;
    localparam int DEF_PW      = 16;

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter shared by the settle, pulse and gap intervals.
// o_zero is high when the loaded interval has fully elapsed.
module fg_prog_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fg_tile_prog_seq.sv
// Sequencer that addresses one floating-gate cell, applies injection
// pulses separated by settle gaps, then strobes a current measurement.
module fg_tile_prog_seq
    import fg_prog_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int ISLANDS = DEF_ISLANDS,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int PW      = DEF_PW,
    localparam int IW = (ISLANDS > 1) ? $clog2(ISLANDS) : 1,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [IW-1:0]      cmd_island,
    input  logic [RW-1:0]      cmd_row,
    input  logic [CW-1:0]      cmd_col,
    input  logic [1:0]         cmd_mode,
    input  logic [PW-1:0]      cmd_pulses,
    input  logic [PW-1:0]      cmd_width,
    output logic [ISLANDS-1:0] island_sel,
    output logic [RW-1:0]      row_addr,
    output logic [CW-1:0]      col_addr,
    output logic               dec_en,
    output logic               prog_en,
    output logic               drain_sel,
    output logic               inj_pulse,
    output logic               meas_strobe,
    output logic               done_valid,
    input  logic               done_ready,
    output logic               done_err
);

    localparam logic [RW:0]   ROW_LIM   = (RW + 1)'(ROWS);
    localparam logic [CW:0]   COL_LIM   = (CW + 1)'(COLS);
    localparam logic [IW:0]   ISL_LIM   = (IW + 1)'(ISLANDS);
    localparam logic [PW-1:0] SETTLE_M1 = PW'(SETTLE - 1);

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_island;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_inj;
    logic          r_err;
    logic [PW-1:0] r_pulses;
    logic [PW-1:0] r_width;

    logic          w_err;
    logic          w_accept;
    logic          w_active;
    logic          w_load;
    logic [PW-1:0] w_load_val;
    logic [PW-1:0] w_wlen;
    logic          w_zero;
    logic          w_pulse_done;

    assign w_err = ({1'b0, cmd_row} >= ROW_LIM)
                 || ({1'b0, cmd_col} >= COL_LIM)
                 || ({1'b0, cmd_island} >= ISL_LIM)
                 || cmd_mode[1];

    assign w_accept = cmd_valid && cmd_ready;

    // Zero width still produces a single-cycle pulse.
    assign w_wlen = (r_width == '0) ? '0 : r_width - 1'b1;

    fg_prog_timer #(.W(PW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_load       = 1'b0;
        w_load_val   = SETTLE_M1;
        w_pulse_done = 1'b0;
        cmd_ready    = 1'b0;
        inj_pulse    = 1'b0;
        meas_strobe  = 1'b0;
        done_valid   = 1'b0;
        done_err     = 1'b0;
        unique case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_err) begin
                        w_next = DONE;
                    end else begin
                        w_next = SETUP;
                        w_load = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (w_zero) begin
                    if (r_inj && (r_pulses != '0)) begin
                        w_next     = PULSE;
                        w_load     = 1'b1;
                        w_load_val = w_wlen;
                    end else begin
                        w_next = MEAS;
                    end
                end
            end
            PULSE: begin
                inj_pulse = 1'b1;
                if (w_zero) begin
                    w_next       = GAP;
                    w_load       = 1'b1;
                    w_pulse_done = 1'b1;
                end
            end
            GAP: begin
                if (w_zero) begin
                    if (r_pulses != '0) begin
                        w_next     = PULSE;
                        w_load     = 1'b1;
                        w_load_val = w_wlen;
                    end else begin
                        w_next = MEAS;
                    end
                end
            end
            MEAS: begin
                meas_strobe = 1'b1;
                w_next      = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                done_err   = r_err;
                if (done_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_island <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_inj    <= 1'b0;
            r_err    <= 1'b0;
            r_pulses <= '0;
            r_width  <= '0;
        end else if (w_accept) begin
            r_island <= cmd_island;
            r_row    <= cmd_row;
            r_col    <= cmd_col;
            r_inj    <= (cmd_mode == MODE_INJ);
            r_err    <= w_err;
            r_pulses <= cmd_pulses;
            r_width  <= cmd_width;
        end else if (w_pulse_done && (r_pulses != '0)) begin
            r_pulses <= r_pulses - 1'b1;
        end
    end

    assign w_active = (r_state == SETUP) || (r_state == PULSE)
                   || (r_state == GAP) || (r_state == MEAS);

    always_comb begin
        island_sel = '0;
        if (w_active) begin
            island_sel[r_island] = 1'b1;
        end
    end

    assign row_addr  = w_active ? r_row : '0;
    assign col_addr  = w_active ? r_col : '0;
    assign dec_en    = w_active;
    assign prog_en   = w_active;
    assign drain_sel = w_active && r_inj;

endmodule
